// File: rtl/clock_rate_controller.sv
// clock_rate_controller: programmable-rate, glitch-free square-wave generator
// with a level req/ack handshake for rate changes aligned to falling edges.
`timescale 1ns/1ps
module clock_rate_controller #(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       RUN,
  input  logic       SEL_REQ,
  input  logic [3:0] SEL,
  output logic       SEL_ACK,
  output logic       SEL_ERR,
  output logic       BUSY,
  output logic [3:0] ACTIVE_SEL,
  output logic       CLOCK_OUT,
  output logic       TICK
);
  typedef enum logic [1:0] {IDLE, RUNNING, SWITCH, STOPPING} state_t;
  // Half-periods in CLK cycles for 1 MHz down to 1 Hz; codes 10-15 are never made active.
  localparam logic [24:0] HALF [16] = '{
    25'(CLK_HZ / 2_000_000), 25'(CLK_HZ / 1_000_000), 25'(CLK_HZ / 200_000),
    25'(CLK_HZ / 100_000), 25'(CLK_HZ / 20_000), 25'(CLK_HZ / 10_000),
    25'(CLK_HZ / 2_000), 25'(CLK_HZ / 200), 25'(CLK_HZ / 20), 25'(CLK_HZ / 2),
    25'd1, 25'd1, 25'd1, 25'd1, 25'd1, 25'd1};
  state_t state;
  logic [24:0] cnt;
  logic [3:0] lat_sel;
  logic rst_ok, stop_pend;
  logic wrap, valid, take;
  assign wrap = cnt == HALF[ACTIVE_SEL] - 25'd1;
  assign valid = SEL < 4'd10;
  assign take = SEL_REQ && !BUSY && !SEL_ACK &&
                (state == IDLE || (state == RUNNING && RUN));
  // Release is resynchronised so the first state update lands on the second edge.
  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) rst_ok <= 1'b0;
    else rst_ok <= 1'b1;
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= IDLE;
      cnt <= '0;
      CLOCK_OUT <= 1'b0;
      TICK <= 1'b0;
      SEL_ACK <= 1'b0;
      SEL_ERR <= 1'b0;
      BUSY <= 1'b0;
      ACTIVE_SEL <= '0;
      lat_sel <= '0;
      stop_pend <= 1'b0;
    end else if (rst_ok) begin
      SEL_ACK <= 1'b0;
      SEL_ERR <= 1'b0;
      TICK <= 1'b0;
      if (take) begin
        SEL_ERR <= !valid;
        if (!valid || state == IDLE) SEL_ACK <= 1'b1;
        if (valid) lat_sel <= SEL;
      end
      if (state == IDLE) begin
        cnt <= '0;
        CLOCK_OUT <= 1'b0;
        if (take && valid) ACTIVE_SEL <= SEL;
        if (RUN) state <= RUNNING;
      end else begin
        cnt <= wrap ? '0 : cnt + 25'd1;
        if (wrap) begin
          CLOCK_OUT <= !CLOCK_OUT;
          TICK <= !CLOCK_OUT;
        end
        case (state)
          RUNNING:
            if (!RUN) begin
              state <= STOPPING;
              BUSY <= 1'b1;
            end else if (take && valid) begin
              state <= SWITCH;
              BUSY <= 1'b1;
            end
          SWITCH: begin
            if (!RUN) stop_pend <= 1'b1;
            // Swap rates only on the falling-edge wrap so neither phase is shortened.
            if (wrap && CLOCK_OUT) begin
              ACTIVE_SEL <= lat_sel;
              SEL_ACK <= 1'b1;
              state <= (stop_pend || !RUN) ? STOPPING : RUNNING;
              BUSY <= stop_pend || !RUN;
              stop_pend <= 1'b0;
            end
          end
          default:
            if (!CLOCK_OUT || wrap) begin
              state <= IDLE;
              BUSY <= 1'b0;
              cnt <= '0;
              CLOCK_OUT <= 1'b0;
              TICK <= 1'b0;
            end
        endcase
      end
    end
  end
endmodule
